// File: rtl/uart_core_host.sv
`default_nettype none
// ============================================================================
// Module      : uart_core_host
// Description : Host-side controller for a CoreUART-style core. It turns the
//               core's CSN/OEN/WEN bus into TX and RX valid/ready byte streams.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_core_host #(
    parameter logic [12:0] BAUD_VALUE    = 13'd1,
    parameter logic        CHAR_BIT8     = 1'b1,
    parameter logic        PARITY_ENABLE = 1'b0,
    parameter logic        PARITY_ODD    = 1'b0,
    parameter int unsigned HOLD_CYCLES   = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [7:0]  TX_DATA,
    input  logic        TX_VALID,
    output logic        TX_READY,
    output logic [7:0]  RX_DATA,
    output logic [2:0]  RX_ERR,
    output logic        RX_VALID,
    input  logic        RX_READY,
    output logic [7:0]  OVF_CNT,
    output logic        CSN,
    output logic        OEN,
    output logic        WEN,
    output logic [7:0]  DATA_IN,
    input  logic [7:0]  DATA_OUT,
    input  logic        TXRDY,
    input  logic        RXRDY,
    input  logic        PARITY_ERR,
    input  logic        FRAMING_ERR,
    input  logic        OVERFLOW,
    output logic [12:0] BAUD_VAL,
    output logic [2:0]  BAUD_VAL_FRACTION,
    output logic        BIT8,
    output logic        PARITY_EN,
    output logic        ODD_N_EVEN
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_STB = 3'd1,
        S_RD_STB = 3'd2,
        S_RD_CAP = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    localparam logic [2:0] c_HOLD_LAST = 3'(HOLD_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_hold_cnt;

    logic        r_txrdy_q;
    logic        r_rxrdy_q;

    logic [7:0]  r_tx_byte;
    logic        r_tx_full;
    logic        r_tx_ready;

    logic [7:0]  r_rx_data;
    logic [2:0]  r_rx_err;
    logic        r_rx_valid;

    logic        r_csn;
    logic        r_oen;
    logic        r_wen;
    logic [7:0]  r_data_in;

    logic        r_ovf_q;
    logic [7:0]  r_ovf_cnt;

    logic        w_tx_accept;
    logic        w_wr_issue;
    logic        w_tx_full_next;
    logic        w_csn_next;
    logic        w_oen_next;
    logic        w_wen_next;

    assign BAUD_VAL          = BAUD_VALUE;
    assign BAUD_VAL_FRACTION = 3'd0;
    assign BIT8              = CHAR_BIT8;
    assign PARITY_EN         = PARITY_ENABLE;
    assign ODD_N_EVEN        = PARITY_ODD;

    assign TX_READY = r_tx_ready;
    assign RX_DATA  = r_rx_data;
    assign RX_ERR   = r_rx_err;
    assign RX_VALID = r_rx_valid;
    assign OVF_CNT  = r_ovf_cnt;
    assign CSN      = r_csn;
    assign OEN      = r_oen;
    assign WEN      = r_wen;
    assign DATA_IN  = r_data_in;

    // Next state; strobes are registered from it so they line up with the state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_rxrdy_q && !r_rx_valid) begin
                    w_state_next = S_RD_STB;
                end else if (r_tx_full && r_txrdy_q) begin
                    w_state_next = S_WR_STB;
                end
            end
            S_WR_STB: w_state_next = S_HOLD;
            S_RD_STB: w_state_next = S_RD_CAP;
            S_RD_CAP: w_state_next = S_HOLD;
            S_HOLD: begin
                if (r_hold_cnt == c_HOLD_LAST) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_csn_next = 1'b1;
        w_oen_next = 1'b1;
        w_wen_next = 1'b1;
        case (w_state_next)
            S_WR_STB: begin
                w_csn_next = 1'b0;
                w_wen_next = 1'b0;
            end
            S_RD_STB, S_RD_CAP: begin
                w_csn_next = 1'b0;
                w_oen_next = 1'b0;
            end
            default: begin
                w_csn_next = 1'b1;
            end
        endcase
    end

    assign w_wr_issue  = (w_state_next == S_WR_STB);
    assign w_tx_accept = TX_VALID && r_tx_ready;

    // Accept and write-issue never coincide: issue needs full, accept needs !full.
    always_comb begin
        w_tx_full_next = r_tx_full;
        if (w_tx_accept) begin
            w_tx_full_next = 1'b1;
        end else if (w_wr_issue) begin
            w_tx_full_next = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= 3'd0;
            r_csn      <= 1'b1;
            r_oen      <= 1'b1;
            r_wen      <= 1'b1;
            r_data_in  <= 8'd0;
            r_txrdy_q  <= 1'b0;
            r_rxrdy_q  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_hold_cnt <= (r_state == S_HOLD) ? r_hold_cnt + 3'd1 : 3'd0;
            r_csn      <= w_csn_next;
            r_oen      <= w_oen_next;
            r_wen      <= w_wen_next;
            r_txrdy_q  <= TXRDY;
            r_rxrdy_q  <= RXRDY;
            if (w_wr_issue) begin
                r_data_in <= r_tx_byte;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_tx_byte  <= 8'd0;
            r_tx_full  <= 1'b0;
            r_tx_ready <= 1'b0;
        end else begin
            r_tx_full  <= w_tx_full_next;
            r_tx_ready <= !w_tx_full_next;
            if (w_tx_accept) begin
                r_tx_byte <= TX_DATA;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_rx_data  <= 8'd0;
            r_rx_err   <= 3'd0;
            r_rx_valid <= 1'b0;
        end else if (r_state == S_RD_CAP) begin
            r_rx_data  <= DATA_OUT;
            r_rx_err   <= {OVERFLOW, FRAMING_ERR, PARITY_ERR};
            r_rx_valid <= 1'b1;
        end else if (RX_READY) begin
            r_rx_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_ovf_q   <= 1'b0;
            r_ovf_cnt <= 8'd0;
        end else begin
            r_ovf_q <= OVERFLOW;
            if (OVERFLOW && !r_ovf_q && (r_ovf_cnt != 8'hFF)) begin
                r_ovf_cnt <= r_ovf_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_core_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_core_host
// Description : Directed plus randomized self-checking bench for uart_core_host.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_core_host;

    localparam int HOLD   = 2;
    localparam int N_RAND = 30;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;
    logic [7:0]  RX_DATA;
    logic [2:0]  RX_ERR;
    logic        RX_VALID;
    logic        RX_READY;
    logic [7:0]  OVF_CNT;
    logic        CSN, OEN, WEN;
    logic [7:0]  DATA_IN;
    logic [7:0]  DATA_OUT;
    logic        TXRDY, RXRDY, PARITY_ERR, FRAMING_ERR, OVERFLOW;
    logic [12:0] BAUD_VAL;
    logic [2:0]  BAUD_VAL_FRACTION;
    logic        BIT8, PARITY_EN, ODD_N_EVEN;

    int checks = 0;
    int errors = 0;

    logic [7:0]  wr_log[$];
    int          oen_cycles = 0;
    int          wen_cycles = 0;

    logic [7:0]  tx_exp[$];
    logic [10:0] rx_exp[$];
    int          base_wr, base_oen, lat;
    int          rx_offered, rx_checked, tx_sent, ovf_edges;
    logic        prev_oen, tx_acc;
    logic [2:0]  err;
    logic [31:0] exp_rx;

    uart_core_host #(
        .BAUD_VALUE    (13'd1),
        .CHAR_BIT8     (1'b1),
        .PARITY_ENABLE (1'b0),
        .PARITY_ODD    (1'b0),
        .HOLD_CYCLES   (HOLD)
    ) dut (
        .CLK               (clk),
        .RESET_N           (rst_n),
        .TX_DATA           (TX_DATA),
        .TX_VALID          (TX_VALID),
        .TX_READY          (TX_READY),
        .RX_DATA           (RX_DATA),
        .RX_ERR            (RX_ERR),
        .RX_VALID          (RX_VALID),
        .RX_READY          (RX_READY),
        .OVF_CNT           (OVF_CNT),
        .CSN               (CSN),
        .OEN               (OEN),
        .WEN               (WEN),
        .DATA_IN           (DATA_IN),
        .DATA_OUT          (DATA_OUT),
        .TXRDY             (TXRDY),
        .RXRDY             (RXRDY),
        .PARITY_ERR        (PARITY_ERR),
        .FRAMING_ERR       (FRAMING_ERR),
        .OVERFLOW          (OVERFLOW),
        .BAUD_VAL          (BAUD_VAL),
        .BAUD_VAL_FRACTION (BAUD_VAL_FRACTION),
        .BIT8              (BIT8),
        .PARITY_EN         (PARITY_EN),
        .ODD_N_EVEN        (ODD_N_EVEN)
    );

    always #5 clk = ~clk;

    // Core-side bus observer: logs every write strobe and strobe-low cycles.
    always @(negedge clk) begin
        if (!CSN && !WEN) wr_log.push_back(DATA_IN);
        if (!OEN) oen_cycles++;
        if (!WEN) wen_cycles++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with activity on the inputs.
        rst_n = 1'b0; TX_VALID = 1'b1; TX_DATA = 8'h77; RXRDY = 1'b1; TXRDY = 1'b1;
        DATA_OUT = 8'h00; PARITY_ERR = 1'b0; FRAMING_ERR = 1'b0; OVERFLOW = 1'b0;
        RX_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_strobes", {CSN, OEN, WEN}, 3'b111);
            chk("rst_tx_ready", TX_READY, 1'b0);
            chk("rst_rx", {RX_VALID, RX_ERR, RX_DATA}, 12'h000);
            chk("rst_data_in", DATA_IN, 8'h00);
            chk("rst_ovf_cnt", OVF_CNT, 8'h00);
        end
        chk("cfg_outputs", {BAUD_VAL, BAUD_VAL_FRACTION, BIT8, PARITY_EN, ODD_N_EVEN},
            {13'd1, 3'd0, 1'b1, 1'b0, 1'b0});
        TX_VALID = 1'b0; RXRDY = 1'b0; rst_n = 1'b1;
        step();
        chk("tx_ready_after_rst", TX_READY, 1'b1);
        chk("strobes_after_rst", {CSN, OEN, WEN}, 3'b111);

        // Single write.
        TX_DATA = 8'hA5; TX_VALID = 1'b1;
        step();
        TX_VALID = 1'b0;
        chk("wr_tx_ready_drop", TX_READY, 1'b0);
        chk("wr_pre_strobe", {CSN, OEN, WEN}, 3'b111);
        step();
        chk("wr_strobe", {CSN, OEN, WEN}, 3'b010);
        chk("wr_data_in", DATA_IN, 8'hA5);
        chk("wr_tx_ready_back", TX_READY, 1'b1);
        step();
        chk("wr_strobe_end", {CSN, OEN, WEN}, 3'b111);
        repeat (4) step();
        chk("wr_wen_cycles", wen_cycles, 1);
        chk("wr_no_oen", oen_cycles, 0);
        chk("wr_data_in_hold", DATA_IN, 8'hA5);

        // Single read with a parity error.
        DATA_OUT = 8'h3C; PARITY_ERR = 1'b1; RXRDY = 1'b1;
        step();
        chk("rd_sample_oen", OEN, 1'b1);
        step();
        chk("rd_strobe1", {CSN, OEN, WEN}, 3'b001);
        chk("rd_valid_early", RX_VALID, 1'b0);
        step();
        chk("rd_strobe2", {CSN, OEN, WEN}, 3'b001);
        step();
        chk("rd_strobe_end", {CSN, OEN, WEN}, 3'b111);
        chk("rd_valid", RX_VALID, 1'b1);
        chk("rd_data_err", {RX_ERR, RX_DATA}, {3'b001, 8'h3C});
        RXRDY = 1'b0; PARITY_ERR = 1'b0; RX_READY = 1'b1;
        step();
        RX_READY = 1'b0;
        chk("rd_handshake_clear", RX_VALID, 1'b0);
        repeat (4) step();
        chk("rd_oen_cycles", oen_cycles, 2);

        // Backpressure: RX held, core has another byte, TX byte pending.
        DATA_OUT = 8'h5A; RXRDY = 1'b1;
        for (int i = 0; i < 12 && RX_VALID !== 1'b1; i++) step();
        chk("bp_first_byte", {RX_VALID, RX_DATA}, {1'b1, 8'h5A});
        DATA_OUT = 8'h6B;
        base_oen = oen_cycles; base_wr = wr_log.size();
        TX_DATA = 8'h22; TX_VALID = 1'b1;
        step();
        TX_VALID = 1'b0;
        for (int i = 0; i < 12 && WEN !== 1'b0; i++) step();
        chk("bp_write_strobe", WEN, 1'b0);
        repeat (6) step();
        chk("bp_write_count", wr_log.size() - base_wr, 1);
        if (wr_log.size() > base_wr) chk("bp_write_byte", wr_log[base_wr], 8'h22);
        chk("bp_no_second_read", oen_cycles - base_oen, 0);
        chk("bp_rx_held", {RX_VALID, RX_DATA}, {1'b1, 8'h5A});
        RX_READY = 1'b1;
        step();
        RX_READY = 1'b0;
        lat = 0;
        while (OEN !== 1'b0 && lat < 10) begin step(); lat++; end
        chk("bp_read_latency", (OEN === 1'b0) && (lat <= 2 + HOLD), 1'b1);
        for (int i = 0; i < 12 && RX_VALID !== 1'b1; i++) step();
        chk("bp_second_byte", {RX_VALID, RX_DATA}, {1'b1, 8'h6B});
        RXRDY = 1'b0; RX_READY = 1'b1;
        step();
        RX_READY = 1'b0;
        repeat (6) step();

        // Simultaneous read and write requests: read first.
        DATA_OUT = 8'h99; RXRDY = 1'b1; TX_DATA = 8'h11; TX_VALID = 1'b1;
        base_wr = wr_log.size();
        step();
        TX_VALID = 1'b0;
        step();
        chk("sim_read_first", {CSN, OEN, WEN}, 3'b001);
        RXRDY = 1'b0;
        for (int i = 0; i < 12 && WEN !== 1'b0; i++) step();
        chk("sim_write_after", {CSN, OEN, WEN}, 3'b010);
        chk("sim_write_byte", DATA_IN, 8'h11);
        chk("sim_rx_byte", {RX_VALID, RX_ERR, RX_DATA}, {1'b1, 3'b000, 8'h99});
        RX_READY = 1'b1;
        step();
        RX_READY = 1'b0;
        repeat (6) step();

        // Randomized traffic against a queue-based model of both streams.
        base_wr = wr_log.size();
        rx_offered = 0; rx_checked = 0; tx_sent = 0; ovf_edges = 0;
        prev_oen = 1'b1; tx_acc = 1'b0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (rx_checked == N_RAND && tx_sent == N_RAND && wr_log.size() - base_wr == N_RAND)
                break;
            // The core presents a new byte once its previous one has been read.
            if (prev_oen === 1'b0 && OEN === 1'b1) RXRDY = 1'b0;
            prev_oen = OEN;
            if (!RXRDY) begin
                err = 3'($urandom_range(0, 7));
                if (rx_offered < N_RAND && $urandom_range(0, 3) == 0) begin
                    DATA_OUT = 8'($urandom_range(0, 255));
                    rx_exp.push_back({err, DATA_OUT});
                    RXRDY = 1'b1;
                    rx_offered++;
                end
                if (!OVERFLOW && err[2]) ovf_edges++;
                {OVERFLOW, FRAMING_ERR, PARITY_ERR} = err;
            end
            TXRDY = ($urandom_range(0, 3) != 0);
            if (TX_VALID !== 1'b1 && tx_sent < N_RAND && $urandom_range(0, 2) == 0) begin
                TX_DATA  = 8'($urandom_range(0, 255));
                TX_VALID = 1'b1;
            end
            RX_READY = ($urandom_range(0, 1) == 1);
            tx_acc = TX_VALID && TX_READY;
            if (tx_acc) begin
                tx_exp.push_back(TX_DATA);
                tx_sent++;
            end
            if (RX_VALID && RX_READY) begin
                if (rx_exp.size() > 0) exp_rx = {21'd0, rx_exp.pop_front()};
                else exp_rx = 32'hDEAD_BEEF;
                chk("rand_rx_byte", {21'd0, RX_ERR, RX_DATA}, exp_rx);
                rx_checked++;
            end
            step();
            if (tx_acc) TX_VALID = 1'b0;
        end
        RX_READY = 1'b0; RXRDY = 1'b0; TXRDY = 1'b1;
        step(); step();
        chk("rand_rx_count", rx_checked, N_RAND);
        chk("rand_rx_leftover", rx_exp.size(), 0);
        chk("rand_tx_count", wr_log.size() - base_wr, N_RAND);
        for (int i = 0; i < tx_exp.size(); i++) begin
            if (base_wr + i < wr_log.size()) chk("rand_tx_byte", wr_log[base_wr + i], tx_exp[i]);
        end
        chk("rand_ovf_cnt", OVF_CNT, (ovf_edges > 255) ? 255 : ovf_edges);

        // Overflow saturation.
        {OVERFLOW, FRAMING_ERR, PARITY_ERR} = 3'b000;
        step(); step();
        for (int i = 0; i < 300; i++) begin
            OVERFLOW = 1'b1; step();
            OVERFLOW = 1'b0; step();
        end
        step();
        chk("ovf_saturate", OVF_CNT, 8'd255);

        // Reset while the read capture cycle is in progress.
        chk("rdcap_pre_valid", RX_VALID, 1'b0);
        DATA_OUT = 8'hC3; RXRDY = 1'b1;
        for (int i = 0; i < 12 && OEN !== 1'b0; i++) step();
        step();
        chk("rdcap_oen_low", OEN, 1'b0);
        rst_n = 1'b0;
        step();
        chk("rst_mid_strobes", {CSN, OEN, WEN}, 3'b111);
        chk("rst_mid_rx_valid", RX_VALID, 1'b0);
        chk("rst_mid_ovf_cnt", OVF_CNT, 8'd0);
        RXRDY = 1'b0; rst_n = 1'b1;
        step(); step();
        chk("rst_mid_after", {RX_VALID, TX_READY}, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
